usb_stream_mux: RTL and testbench
=================================

USB_STREAM_MUX -- requirements
Module: usb_stream_mux

Interface
REQ-001 SHALL have parameter NCH, default 2: number of source channels, range 1..4.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9: per-channel FIFO depth is 2^DEPTH_LOG2 bytes.
REQ-003 SHALL have parameter MAX_BURST, default 64: maximum payload bytes per packet, range 1..255.
REQ-004 CLK  in  1  single clock, FT232H CLKOUT (60 MHz); all logic in this domain.
REQ-005 RST  in  1  reset, asynchronous and active-high.
REQ-006 CH_DATA  in  8*NCH  source bytes; channel n occupies bits [8n+7:8n].
REQ-007 CH_WR  in  NCH  per-channel write strobes.
REQ-008 CH_FULL  out  NCH  per-channel FIFO full.
REQ-009 CH_OVF  out  NCH  sticky per-channel overflow flag.
REQ-010 USB_D_I  in  8  FT232H data bus, input side.
REQ-011 USB_D_O  out  8  FT232H data bus, output side.
REQ-012 USB_D_OE  out  1  bus drive enable (1 = FPGA drives).
REQ-013 USB_RXF_N, USB_TXE_N  in  1 each  FT232H sync-FIFO status, active-low.
REQ-014 USB_RD_N, USB_WR_N, USB_OE_N  out  1 each  FT232H sync-FIFO strobes, active-low.
REQ-015 RX_DATA  out  8  host-to-FPGA byte.
REQ-016 RX_VALID  out  1  one-cycle qualifier for RX_DATA.
REQ-017 RX_READY  in  1  downstream can accept an RX byte.

Function
REQ-018 Each channel SHALL own a FIFO; a byte SHALL be enqueued when CH_WR[n]=1 and CH_FULL[n]=0.
REQ-019 CH_WR[n]=1 while CH_FULL[n]=1 SHALL drop the byte and set CH_OVF[n]=1 until reset.
REQ-020 CH_FULL[n] SHALL be 1 exactly when the FIFO holds 2^DEPTH_LOG2 bytes; simultaneous enqueue and dequeue SHALL leave the count unchanged.
REQ-021 Outgoing packet format SHALL be: header 0xA0|n, length byte L, then L payload bytes, oldest first.
REQ-022 L SHALL equal min(FIFO count, MAX_BURST), snapshotted in the cycle the header is sent; bytes enqueued later SHALL wait for a later packet.
REQ-023 Channel selection SHALL be round-robin among non-empty channels, starting with the channel after the last served one; after reset, channel 0 has first priority.
REQ-024 States SHALL be IDLE, HDR, LEN, DATA, RX_TURN, RX_READ.
REQ-025 In IDLE, if USB_RXF_N=0 and RX_READY=1, the FSM SHALL go to RX_TURN; otherwise, if any channel is non-empty, it SHALL go to HDR; RX has priority only at packet boundaries.
REQ-026 In HDR, LEN and DATA: USB_D_OE=1 and USB_WR_N = USB_TXE_N (combinational); a byte is transferred on each edge with USB_WR_N=0.
REQ-027 While USB_TXE_N=1, USB_D_O SHALL hold the pending byte and the FSM SHALL stall; no byte SHALL be lost or duplicated.
REQ-028 After the L-th payload byte transfers, the FSM SHALL return to IDLE.
REQ-029 RX_TURN SHALL last one cycle with USB_OE_N=0, USB_D_OE=0, and USB_RD_N=1.
REQ-030 In RX_READ: USB_OE_N=0 and USB_RD_N = ~(~USB_RXF_N & RX_READY) (combinational); each byte read SHALL appear on RX_DATA with RX_VALID=1 on the following cycle.
REQ-031 RX_READ SHALL exit to IDLE when USB_RXF_N=1 or RX_READY=0; USB_OE_N SHALL be 1 in the IDLE cycle.
REQ-032 USB_D_OE SHALL never be 1 in any cycle where USB_OE_N=0.

Reset
REQ-033 While RST=1: USB_RD_N=1, USB_WR_N=1, USB_OE_N=1, USB_D_OE=0, USB_D_O=0, RX_VALID=0, RX_DATA=0, CH_FULL=0, CH_OVF=0, FSM=IDLE, all FIFOs empty, and round-robin pointer=0.
REQ-034 RST asserted mid-packet SHALL abandon the packet; no residual bytes SHALL be emitted after release.

Verification
REQ-035 NCH=2, DEPTH_LOG2=4, MAX_BURST=8; ch0 writes 11,22,33; TXE_N=0 -> bus carries A0 03 11 22 33, WR_N low exactly 5 cycles.
REQ-036 Same parameters; ch0 and ch1 each get 10 bytes -> packets in order: A0 08, A1 08, A0 02, A1 02, with payload order preserved.
REQ-037 TXE_N forced high for 4 cycles after the second payload byte -> WR_N high for those 4 cycles, D_O stable, and the full payload is received once.
REQ-038 TXE_N=1; ch1 gets 17 writes -> CH_FULL[1]=1 after the 16th write, CH_OVF[1]=1 after the 17th; after TXE_N=0, A1 08 followed by the first 8 bytes is observed.
REQ-039 RXF_N low presenting 5A, C3; RX_READY=1 -> OE_N falls one cycle before RD_N; RX_VALID pulses with 5A then C3; D_OE=0 throughout.
REQ-040 RST pulsed during DATA of a 3-byte packet -> all outputs at reset values asynchronously; after release, bus idle with no stale header or payload.

Source files
------------

// File: rtl/usb_stream_mux.sv
// Packs NCH byte streams into [A0|n, L, payload] packets on an FT232H sync FIFO and forwards host bytes to RX.
// Latency: a byte written to an empty idle channel becomes eligible two cycles later; RX bytes appear one cycle after their read strobe.
// Backpressure: TXE_N stalls the bus FSM with the pending byte held; full channel FIFOs drop writes and set sticky overflow; RX_READY gates host reads.
module usb_stream_mux #(
    parameter int NCH        = 2,
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_BURST  = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [8*NCH-1:0]   CH_DATA,
    input  logic [NCH-1:0]     CH_WR,
    output logic [NCH-1:0]     CH_FULL,
    output logic [NCH-1:0]     CH_OVF,
    input  logic [7:0]         USB_D_I,
    output logic [7:0]         USB_D_O,
    output logic               USB_D_OE,
    input  logic               USB_RXF_N,
    input  logic               USB_TXE_N,
    output logic               USB_RD_N,
    output logic               USB_WR_N,
    output logic               USB_OE_N,
    output logic [7:0]         RX_DATA,
    output logic               RX_VALID,
    input  logic               RX_READY
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CHW:0]          NCH_W    = (CHW + 1)'(NCH);
    localparam logic [CHW-1:0]        LAST_CH  = CHW'(NCH - 1);
    localparam logic [CHW-1:0]        CH_ONE   = CHW'(1);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, RX_TURN, RX_READ} state_t;
    state_t state, state_nxt;

    logic [CHW-1:0]      cur_ch, rr_ptr, sel_ch;
    logic                sel_vld;
    logic [7:0]          remaining;
    logic [7:0]          cur_len;
    logic [CW-1:0]       cnt_cur;
    logic                tx_fire, rd_fire;
    logic [NCH-1:0]      nonempty;
    logic [8*NCH-1:0]    head_flat;
    logic [CW*NCH-1:0]   count_flat;
    logic [2*NCH-1:0]    rot;

    // A bus byte moves on every edge where the FSM offers one and the FT232H has room.
    assign tx_fire = ((state == HDR) || (state == LEN) || (state == DATA)) && !USB_TXE_N;
    // A host byte is consumed on every RX_READ edge where data exists and downstream accepts.
    assign rd_fire = (state == RX_READ) && !USB_RXF_N && RX_READY;

    genvar g;
    for (g = 0; g < NCH; g++) begin : g_ch
        logic [7:0]            mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0]         count;
        logic                  ovf;
        logic                  enq, deq;

        assign enq = CH_WR[g] && !CH_FULL[g];
        assign deq = tx_fire && (state == DATA) && (cur_ch == CHW'(g));
        assign CH_FULL[g]  = (count == FULL_CNT);
        assign CH_OVF[g]   = ovf;
        assign nonempty[g] = (count != '0);
        assign head_flat[8*g +: 8]   = mem[rd_ptr];
        assign count_flat[CW*g +: CW] = count;

        // Storage array: only accepted bytes are written, contents need no reset.
        always_ff @(posedge CLK) begin
            if (enq) mem[wr_ptr] <= CH_DATA[8*g +: 8];
        end

        // Pointers, occupancy and the sticky overflow flag.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PTR_ONE;
                if (deq) rd_ptr <= rd_ptr + PTR_ONE;
                if (enq && !deq)      count <= count + CNT_ONE;
                else if (!enq && deq) count <= count - CNT_ONE;
                if (CH_WR[g] && CH_FULL[g]) ovf <= 1'b1;
            end
        end
    end

    // Round-robin pick: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        logic [CHW:0] idx;
        idx     = '0;
        sel_vld = 1'b0;
        sel_ch  = '0;
        rot     = {nonempty, nonempty} >> rr_ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = {1'b0, rr_ptr} + k[CHW:0];
                if (idx >= NCH_W) idx = idx - NCH_W;
                sel_vld = 1'b1;
                sel_ch  = idx[CHW-1:0];
            end
        end
    end

    // Packet length is the current channel occupancy clipped to MAX_BURST.
    always_comb begin
        cnt_cur = count_flat[CW*cur_ch +: CW];
        if (32'(cnt_cur) > MAX_BURST) cur_len = 8'(MAX_BURST);
        else                          cur_len = 8'(cnt_cur);
    end

    // State, packet bookkeeping and the registered RX output stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cur_ch    <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            RX_DATA   <= '0;
            RX_VALID  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == HDR) begin
                cur_ch <= sel_ch;
                rr_ptr <= (sel_ch == LAST_CH) ? '0 : sel_ch + CH_ONE;
            end
            // Length is frozen when the header goes out; later writes wait.
            if (state == HDR && tx_fire)  remaining <= cur_len;
            if (state == DATA && tx_fire) remaining <= remaining - 8'd1;
            RX_VALID <= rd_fire;
            if (rd_fire) RX_DATA <= USB_D_I;
        end
    end

    // Next-state and bus strobes; the bus is driven only in TX states, OE_N only low in RX states.
    always_comb begin
        state_nxt = state;
        USB_D_O   = 8'h00;
        USB_D_OE  = 1'b0;
        USB_WR_N  = 1'b1;
        USB_RD_N  = 1'b1;
        USB_OE_N  = 1'b1;
        case (state)
            IDLE: begin
                if (!USB_RXF_N && RX_READY) state_nxt = RX_TURN;
                else if (sel_vld)           state_nxt = HDR;
            end
            HDR: begin
                USB_D_OE = 1'b1;
                USB_WR_N = USB_TXE_N;
                USB_D_O  = 8'hA0 | 8'(cur_ch);
                if (tx_fire) state_nxt = LEN;
            end
            LEN: begin
                USB_D_OE = 1'b1;
                USB_WR_N = USB_TXE_N;
                USB_D_O  = remaining;
                if (tx_fire) state_nxt = DATA;
            end
            DATA: begin
                USB_D_OE = 1'b1;
                USB_WR_N = USB_TXE_N;
                USB_D_O  = head_flat[8*cur_ch +: 8];
                if (tx_fire && remaining == 8'd1) state_nxt = IDLE;
            end
            RX_TURN: begin
                USB_OE_N  = 1'b0;
                state_nxt = RX_READ;
            end
            RX_READ: begin
                USB_OE_N = 1'b0;
                USB_RD_N = ~(~USB_RXF_N & RX_READY);
                if (USB_RXF_N || !RX_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_stream_mux.sv
// Self-checking bench for usb_stream_mux (NCH=2, DEPTH_LOG2=4, MAX_BURST=8).
// Stimulus: directed scenarios plus randomized channel writes, TXE_N stalls and RX_READY throttling.
// Expectations come from per-channel byte queues and a packet-level round-robin model.
module tb_usb_stream_mux;
    localparam int NCH = 2;
    localparam int DEPTH_LOG2 = 4;
    localparam int MAX_BURST = 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [8*NCH-1:0] CH_DATA = '0;
    logic [NCH-1:0]   CH_WR = '0;
    logic [NCH-1:0]   CH_FULL, CH_OVF;
    logic [7:0]       USB_D_I = '0;
    logic [7:0]       USB_D_O;
    logic             USB_D_OE;
    logic             USB_RXF_N = 1'b1;
    logic             USB_TXE_N = 1'b1;
    logic             USB_RD_N, USB_WR_N, USB_OE_N;
    logic [7:0]       RX_DATA;
    logic             RX_VALID;
    logic             RX_READY = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [7:0] bus_q[$];
    int         wr_low_cnt = 0;
    logic [7:0] mq [NCH][$];
    logic [NCH-1:0] movf;
    logic [7:0] exp_q[$];

    usb_stream_mux #(.NCH(NCH), .DEPTH_LOG2(DEPTH_LOG2), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST(RST), .CH_DATA(CH_DATA), .CH_WR(CH_WR), .CH_FULL(CH_FULL), .CH_OVF(CH_OVF),
        .USB_D_I(USB_D_I), .USB_D_O(USB_D_O), .USB_D_OE(USB_D_OE), .USB_RXF_N(USB_RXF_N),
        .USB_TXE_N(USB_TXE_N), .USB_RD_N(USB_RD_N), .USB_WR_N(USB_WR_N), .USB_OE_N(USB_OE_N),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY)
    );

    always #5 CLK = ~CLK;

    // Bus monitor: every cycle with WR_N low is one byte taken by the FT232H.
    always @(negedge CLK) begin
        if (!USB_WR_N) begin
            bus_q.push_back(USB_D_O);
            wr_low_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        CH_WR = '0; CH_DATA = '0; USB_TXE_N = 1'b1; USB_RXF_N = 1'b1; USB_D_I = '0; RX_READY = 1'b1;
        for (int n = 0; n < NCH; n++) mq[n].delete();
        movf = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        tick();
    endtask

    // One write cycle; the model accepts a byte only while its queue is below capacity.
    task automatic write_cycle(input logic [NCH-1:0] wr, input logic [8*NCH-1:0] dat);
        CH_WR = wr;
        CH_DATA = dat;
        for (int n = 0; n < NCH; n++) begin
            if (wr[n]) begin
                if (mq[n].size() < DEPTH) mq[n].push_back(dat[8*n +: 8]);
                else movf[n] = 1'b1;
            end
        end
        tick();
        CH_WR = '0;
    endtask

    // Packet-level model: round-robin from channel 0, L = min(queued, MAX_BURST).
    task automatic build_expected();
        int rr;
        int n;
        int len;
        bit done;
        rr = 0;
        done = 0;
        exp_q.delete();
        while (!done) begin
            n = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (rr + k) % NCH;
                if (n < 0 && mq[c].size() > 0) n = c;
            end
            if (n < 0) done = 1;
            else begin
                len = (mq[n].size() > MAX_BURST) ? MAX_BURST : mq[n].size();
                exp_q.push_back(8'hA0 | 8'(n));
                exp_q.push_back(8'(len));
                for (int i = 0; i < len; i++) exp_q.push_back(mq[n].pop_front());
                rr = (n + 1) % NCH;
            end
        end
    endtask

    task automatic wait_bus(input int base, input int n, input int budget, input bit rand_txe, output bit timed_out);
        int cyc;
        cyc = 0;
        while ((bus_q.size() - base) < n && cyc < budget) begin
            if (rand_txe) USB_TXE_N = 1'($urandom_range(0, 1));
            else USB_TXE_N = 1'b0;
            tick();
            cyc++;
        end
        timed_out = ((bus_q.size() - base) < n);
        USB_TXE_N = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (USB_WR_N !== 1'b1) begin failures++; $display("FAIL rst_wr_n got=%b exp=1", USB_WR_N); end
        checks++; if (USB_RD_N !== 1'b1) begin failures++; $display("FAIL rst_rd_n got=%b exp=1", USB_RD_N); end
        checks++; if (USB_OE_N !== 1'b1) begin failures++; $display("FAIL rst_oe_n got=%b exp=1", USB_OE_N); end
        checks++; if (USB_D_OE !== 1'b0) begin failures++; $display("FAIL rst_d_oe got=%b exp=0", USB_D_OE); end
        checks++; if (USB_D_O !== 8'h00) begin failures++; $display("FAIL rst_d_o got=%h exp=00", USB_D_O); end
        checks++; if (RX_VALID !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", RX_VALID); end
        checks++; if (RX_DATA !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", RX_DATA); end
        checks++; if (CH_FULL !== 2'b00) begin failures++; $display("FAIL rst_ch_full got=%b exp=00", CH_FULL); end
        checks++; if (CH_OVF !== 2'b00) begin failures++; $display("FAIL rst_ch_ovf got=%b exp=00", CH_OVF); end
        @(posedge CLK);
        #1 RST = 1'b0;
        tick();
    endtask

    task automatic test_single_packet();
        logic [7:0] want [5];
        int base, wbase, got_n;
        bit to;
        want[0] = 8'hA0; want[1] = 8'h03; want[2] = 8'h11; want[3] = 8'h22; want[4] = 8'h33;
        do_reset();
        write_cycle(2'b01, 16'h0011);
        write_cycle(2'b01, 16'h0022);
        write_cycle(2'b01, 16'h0033);
        base = bus_q.size();
        wbase = wr_low_cnt;
        wait_bus(base, 5, 100, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL single_timeout got=%0d bytes exp=5", bus_q.size() - base); end
        got_n = bus_q.size() - base;
        checks++; if (wr_low_cnt - wbase != 5) begin failures++; $display("FAIL single_wr_low got=%0d exp=5", wr_low_cnt - wbase); end
        for (int i = 0; i < 5 && i < got_n; i++) begin
            checks++;
            if (bus_q[base + i] !== want[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, bus_q[base + i], want[i]); end
        end
    endtask

    task automatic test_round_robin();
        int base, got_n;
        bit to;
        do_reset();
        for (int i = 0; i < 10; i++) write_cycle(2'b11, {8'h80 + 8'(i), 8'h10 + 8'(i)});
        build_expected();
        base = bus_q.size();
        wait_bus(base, exp_q.size(), 300, 1'b0, to);
        got_n = bus_q.size() - base;
        checks++; if (got_n != exp_q.size()) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", got_n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
            checks++;
            if (bus_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d got=%h exp=%h", i, bus_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] want [5];
        int base, n, cyc, got_n;
        bit to;
        want[0] = 8'hA0; want[1] = 8'h03; want[2] = 8'h11; want[3] = 8'h22; want[4] = 8'h33;
        do_reset();
        write_cycle(2'b01, 16'h0011);
        write_cycle(2'b01, 16'h0022);
        write_cycle(2'b01, 16'h0033);
        base = bus_q.size();
        USB_TXE_N = 1'b0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 50) begin
            @(negedge CLK);
            if (!USB_WR_N) n++;
            tick();
            cyc++;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL stall_reach got=%0d transfers exp=4", n); end
        USB_TXE_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++; if (USB_WR_N !== 1'b1) begin failures++; $display("FAIL stall_wr_n cyc%0d got=%b exp=1", c, USB_WR_N); end
            checks++; if (USB_D_O !== 8'h33) begin failures++; $display("FAIL stall_d_o cyc%0d got=%h exp=33", c, USB_D_O); end
        end
        tick();
        wait_bus(base, 5, 100, 1'b0, to);
        got_n = bus_q.size() - base;
        checks++; if (got_n != 5) begin failures++; $display("FAIL stall_len got=%0d exp=5", got_n); end
        for (int i = 0; i < 5 && i < got_n; i++) begin
            checks++;
            if (bus_q[base + i] !== want[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, bus_q[base + i], want[i]); end
        end
    endtask

    task automatic test_overflow();
        int base, got_n;
        bit to;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            write_cycle(2'b10, {8'h40 + 8'(i), 8'h00});
            if (i == 14) begin
                checks++; if (CH_FULL !== 2'b00) begin failures++; $display("FAIL ovf_full15 got=%b exp=00", CH_FULL); end
            end
            if (i == 15) begin
                checks++; if (CH_FULL !== 2'b10) begin failures++; $display("FAIL ovf_full16 got=%b exp=10", CH_FULL); end
                checks++; if (CH_OVF !== 2'b00) begin failures++; $display("FAIL ovf_flag16 got=%b exp=00", CH_OVF); end
            end
        end
        checks++; if (CH_OVF !== movf) begin failures++; $display("FAIL ovf_flag17 got=%b exp=%b", CH_OVF, movf); end
        build_expected();
        base = bus_q.size();
        wait_bus(base, exp_q.size(), 300, 1'b0, to);
        got_n = bus_q.size() - base;
        checks++; if (got_n != exp_q.size()) begin failures++; $display("FAIL ovf_len got=%0d exp=%0d", got_n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
            checks++;
            if (bus_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, bus_q[base + i], exp_q[i]); end
        end
        checks++; if (CH_FULL !== 2'b00) begin failures++; $display("FAIL ovf_full_after got=%b exp=00", CH_FULL); end
        checks++; if (CH_OVF !== 2'b10) begin failures++; $display("FAIL ovf_sticky got=%b exp=10", CH_OVF); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] src [2];
        logic [7:0] got[$];
        int idx, first_oe, first_rd, oe_low, doe_bad, late;
        bit prev_rd, reading;
        src[0] = 8'h5A; src[1] = 8'hC3;
        do_reset();
        idx = 0; first_oe = -1; first_rd = -1; oe_low = 0; doe_bad = 0; late = 0; prev_rd = 0;
        USB_D_I = src[0];
        USB_RXF_N = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!USB_OE_N) oe_low++;
            if (!USB_OE_N && first_oe < 0) first_oe = c;
            if (!USB_RD_N && first_rd < 0) first_rd = c;
            if (USB_D_OE) doe_bad++;
            if (RX_VALID) begin
                got.push_back(RX_DATA);
                if (!prev_rd) late++;
            end
            reading = !USB_RD_N && !USB_OE_N;
            prev_rd = reading;
            tick();
            if (reading) begin
                idx++;
                if (idx < 2) USB_D_I = src[idx];
                else USB_RXF_N = 1'b1;
            end
        end
        checks++; if (first_oe < 0 || first_rd != first_oe + 1) begin failures++; $display("FAIL rx_turn rd_cycle=%0d oe_cycle=%0d exp rd=oe+1", first_rd, first_oe); end
        checks++; if (oe_low != 4) begin failures++; $display("FAIL rx_oe_cycles got=%0d exp=4", oe_low); end
        checks++; if (doe_bad != 0) begin failures++; $display("FAIL rx_d_oe got=%0d driven cycles exp=0", doe_bad); end
        checks++; if (late != 0) begin failures++; $display("FAIL rx_valid_timing got=%0d stray exp=0", late); end
        checks++; if (got.size() != 2) begin failures++; $display("FAIL rx_count got=%0d exp=2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== src[i]) begin failures++; $display("FAIL rx_byte%0d got=%h exp=%h", i, got[i], src[i]); end
        end
        checks++; if (USB_OE_N !== 1'b1) begin failures++; $display("FAIL rx_oe_idle got=%b exp=1", USB_OE_N); end
    endtask

    task automatic test_rx_random();
        logic [7:0] src [12];
        logic [7:0] got[$];
        int idx, bad, late, cyc;
        bit prev_rd, reading;
        for (int i = 0; i < 12; i++) src[i] = 8'($urandom);
        do_reset();
        idx = 0; bad = 0; late = 0; cyc = 0; prev_rd = 0;
        USB_D_I = src[0];
        USB_RXF_N = 1'b0;
        while ((got.size() < 12 || cyc < 20) && cyc < 600) begin
            @(negedge CLK);
            if (USB_D_OE && !USB_OE_N) bad++;
            if (RX_VALID) begin
                got.push_back(RX_DATA);
                if (!prev_rd) late++;
            end
            reading = !USB_RD_N && !USB_OE_N;
            prev_rd = reading;
            tick();
            RX_READY = ($urandom_range(0, 3) != 0);
            if (reading) begin
                idx++;
                if (idx < 12) USB_D_I = src[idx];
                else USB_RXF_N = 1'b1;
            end
            cyc++;
        end
        checks++; if (got.size() != 12) begin failures++; $display("FAIL rxr_count got=%0d exp=12", got.size()); end
        checks++; if (bad != 0) begin failures++; $display("FAIL rxr_bus_conflict got=%0d exp=0", bad); end
        checks++; if (late != 0) begin failures++; $display("FAIL rxr_valid_timing got=%0d exp=0", late); end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== src[i]) begin failures++; $display("FAIL rxr_byte%0d got=%h exp=%h", i, got[i], src[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int n, cyc, wbase;
        do_reset();
        write_cycle(2'b01, 16'h0011);
        write_cycle(2'b01, 16'h0022);
        write_cycle(2'b01, 16'h0033);
        USB_TXE_N = 1'b0;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            @(negedge CLK);
            if (!USB_WR_N) n++;
            tick();
            cyc++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL mid_reach got=%0d transfers exp=3", n); end
        #2 RST = 1'b1;
        #1;
        checks++; if (USB_WR_N !== 1'b1) begin failures++; $display("FAIL mid_wr_n got=%b exp=1", USB_WR_N); end
        checks++; if (USB_D_OE !== 1'b0) begin failures++; $display("FAIL mid_d_oe got=%b exp=0", USB_D_OE); end
        checks++; if (USB_D_O !== 8'h00) begin failures++; $display("FAIL mid_d_o got=%h exp=00", USB_D_O); end
        checks++; if (CH_FULL !== 2'b00 || CH_OVF !== 2'b00) begin failures++; $display("FAIL mid_flags got=%b/%b exp=00/00", CH_FULL, CH_OVF); end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < NCH; i++) mq[i].delete();
        wbase = wr_low_cnt;
        repeat (20) tick();
        checks++; if (wr_low_cnt != wbase) begin failures++; $display("FAIL mid_residual got=%0d bytes exp=0", wr_low_cnt - wbase); end
    endtask

    task automatic test_random();
        int ncyc, base, got_n;
        logic [NCH-1:0] wr;
        logic [NCH-1:0] full_exp;
        bit to;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            ncyc = $urandom_range(5, 30);
            for (int c = 0; c < ncyc; c++) begin
                wr = NCH'($urandom_range(0, 3));
                if (c == 0) wr[0] = 1'b1;
                write_cycle(wr, 16'($urandom));
            end
            for (int i = 0; i < NCH; i++) full_exp[i] = (mq[i].size() == DEPTH);
            checks++; if (CH_OVF !== movf) begin failures++; $display("FAIL rnd%0d_ovf got=%b exp=%b", r, CH_OVF, movf); end
            checks++; if (CH_FULL !== full_exp) begin failures++; $display("FAIL rnd%0d_full got=%b exp=%b", r, CH_FULL, full_exp); end
            build_expected();
            base = bus_q.size();
            wait_bus(base, exp_q.size(), 3000, 1'b1, to);
            got_n = bus_q.size() - base;
            checks++; if (got_n != exp_q.size()) begin failures++; $display("FAIL rnd%0d_len got=%0d exp=%0d", r, got_n, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
                checks++;
                if (bus_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", r, i, bus_q[base + i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stall();
        test_overflow();
        test_rx_basic();
        test_rx_random();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
